// File: rtl/matrix_mac_stream_loader.sv
// Streams an operand image into shared BRAM, kicks the PE controller,
// then streams the result region back out on AXI-Stream.
//
// Ports:
//   aclk, areset          clock, async active-high reset
//   s_axis_*              operand slave stream (tdata/tvalid/tready/tlast)
//   m_axis_*              result master stream (tdata/tvalid/tready/tlast)
//   pe_start, pe_done     PE controller handshake
//   bram_own              1 = this block owns the BRAM port
//   BRAM_ADDR/WRDATA/WE   BRAM port (byte address, 1-cycle read latency)
//   BRAM_RDDATA           BRAM read data
//   busy, err_len         status (err_len is sticky framing error)
//   run_cycles            PE run time in cycles
// Option: MATRIX_MAC_LOADER_CYCLE_COUNT_EN builds the run_cycles counter.
module matrix_mac_stream_loader #(
  parameter int LOAD_WORDS      = 4160,
  parameter int RESULT_BASE     = 4160,
  parameter int RESULT_WORDS    = 64,
  parameter int BRAM_ADDR_WIDTH = 15
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        pe_start,
  input  logic        pe_done,
  output logic        bram_own,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  input  logic [31:0] BRAM_RDDATA,
  output logic        busy,
  output logic        err_len,
  output logic [31:0] run_cycles
);

  localparam int CW = $clog2(LOAD_WORDS + 1);
  localparam logic [CW-1:0] LAST_W = CW'(LOAD_WORDS - 1);
  localparam logic [CW-1:0] LAST_R = CW'(RESULT_WORDS - 1);

  if (RESULT_BASE + RESULT_WORDS > (1 << (BRAM_ADDR_WIDTH - 2)))
  begin : g_bad_params
    $error("result region exceeds BRAM address range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN,
    S_RD_ADDR, S_RD_WAIT, S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          rdy_q, rdy_d;
  logic          start_q, start_d;
  logic          own_q, own_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          beat;

  assign beat = s_axis_tvalid & rdy_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    start_d  = 1'b0;
    own_d    = own_q;
    we_d     = 4'h0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (beat) begin
          we_d    = 4'hF;
          addr_d  = 32'(wcnt_q) << 2;
          wdata_d = s_axis_tdata;
          if (state_q == S_IDLE) err_d = 1'b0;
          if (wcnt_q == LAST_W) begin
            state_d = S_START;
            wcnt_d  = wcnt_q + 1'b1;
            if (!s_axis_tlast) err_d = 1'b1;
          end else if (s_axis_tlast) begin
            // short frame: drop the job, never start the PE
            state_d = S_IDLE;
            wcnt_d  = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
            wcnt_d  = wcnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        own_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pe_done) begin
          own_d   = 1'b1;
          addr_d  = (32'(RESULT_BASE) + 32'(rcnt_q)) << 2;
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tdata_d  = BRAM_RDDATA;
        tvalid_d = 1'b1;
        tlast_d  = (rcnt_q == LAST_R);
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
            wcnt_d  = '0;
          end else begin
            rcnt_d  = rcnt_q + 1'b1;
            addr_d  = (32'(RESULT_BASE) + 32'(rcnt_q) + 32'd1) << 2;
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      rdy_q    <= 1'b1;
      start_q  <= 1'b0;
      own_q    <= 1'b1;
      we_q     <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      rdy_q    <= rdy_d;
      start_q  <= start_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

`ifdef MATRIX_MAC_LOADER_CYCLE_COUNT_EN
  logic [31:0] run_q, run_d;

  // frozen once pe_done is seen, held until the next job starts
  always_comb begin
    run_d = run_q;
    if (state_q == S_START) run_d = '0;
    else if (state_q == S_RUN && !pe_done) run_d = run_q + 32'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) run_q <= '0;
    else        run_q <= run_d;
  end

  assign run_cycles = run_q;
`else
  assign run_cycles = 32'd0;
`endif

  assign s_axis_tready = rdy_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pe_start      = start_q;
  assign bram_own      = own_q;
  assign BRAM_ADDR     = addr_q;
  assign BRAM_WRDATA   = wdata_q;
  assign BRAM_WE       = we_q;
  assign busy          = busy_q;
  assign err_len       = err_q;

endmodule
